// File: rtl/conv_via_tiling_tile_index_gen.sv
// rtl/conv_via_tiling_tile_index_gen.sv - flat-index iterator splitting indices into tile row/column
// Divides by a constant through reciprocal multiplication on an external combinational multiplier.
module conv_via_tiling_tile_index_gen #(
    parameter int unsigned  DIVISOR = 28,
    parameter logic [35:0]  MAGIC   = 36'd4908534053,
    parameter int unsigned  SHIFT   = 37
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_idle,
    output logic        ap_done,
    output logic        ap_ready,
    input  logic [31:0] base,
    input  logic [31:0] count,
    output logic [31:0] mul_din0,
    output logic [35:0] mul_din1,
    input  logic [67:0] mul_dout,
    output logic [31:0] out_idx,
    output logic [31:0] out_q,
    output logic [31:0] out_r,
    output logic        out_vld,
    input  logic        out_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] idx0_q;
    logic [31:0] rem_q;
    logic        s1_vld_q;
    logic [31:0] s1_idx_q;
    logic [67:0] s1_prod_q;
    logic        out_vld_q;
    logic [31:0] out_idx_q, out_q_q, out_r_q;

    logic        advance;
    logic        issue;
    logic [31:0] quo_c;
    logic [31:0] rem_c;

    // A held output freezes the whole pipe, so a single advance enable suffices.
    assign advance = !(out_vld_q && !out_ack);
    assign issue   = (state_q == S_RUN) && (rem_q != 32'd0) && advance;

    assign quo_c = 32'(s1_prod_q >> SHIFT);
    assign rem_c = s1_idx_q - quo_c * 32'(DIVISOR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = (count == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && rem_q == 32'd1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!s1_vld_q && out_vld_q && out_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            idx0_q    <= 32'd0;
            rem_q     <= 32'd0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= 32'd0;
            s1_prod_q <= 68'd0;
            out_vld_q <= 1'b0;
            out_idx_q <= 32'd0;
            out_q_q   <= 32'd0;
            out_r_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && ap_start) begin
                idx0_q <= base;
                rem_q  <= count;
            end else if (issue) begin
                idx0_q <= idx0_q + 32'd1;
                rem_q  <= rem_q - 32'd1;
            end
            if (advance) begin
                s1_vld_q  <= issue;
                s1_idx_q  <= idx0_q;
                s1_prod_q <= mul_dout;
                out_vld_q <= s1_vld_q;
                // Output data only changes when a real result arrives.
                if (s1_vld_q) begin
                    out_idx_q <= s1_idx_q;
                    out_q_q   <= quo_c;
                    out_r_q   <= rem_c;
                end
            end
        end
    end

    assign mul_din0 = idx0_q;
    assign mul_din1 = MAGIC;
    assign ap_idle  = (state_q == S_IDLE);
    assign ap_done  = (state_q == S_DONE);
    assign ap_ready = (state_q == S_DONE);
    assign out_vld  = out_vld_q;
    assign out_idx  = out_idx_q;
    assign out_q    = out_q_q;
    assign out_r    = out_r_q;

endmodule

// File: doc/conv_via_tiling_tile_index_gen.md
Name: conv_via_tiling_tile_index_gen

Overview:
Flat-index iterator for the tiled convolution loop nest. It generates consecutive 32-bit flat indices and splits each into a tile row (quotient) and tile column (remainder) by a constant DIVISOR. The split uses reciprocal multiplication: the block drives the combinational 32ns x 36ns -> 68-bit unsigned multiplier (NUM_STAGE=0) and consumes its product. Results leave through a valid/ack stream toward the tile address/load stage.

Parameters:
DIVISOR, 28, tile width; constant divisor, 2..2^16
MAGIC, 4908534053, 36-bit reciprocal = floor(2^(32+L)/DIVISOR)+1, where L = ceil(log2 DIVISOR)
SHIFT, 37, right-shift applied to product = 32+L

Ports:
ap_clk  in  1  clock; all state updates on the rising edge
ap_rst  in  1  synchronous reset, active-high
ap_start  in  1  start request; sampled only in IDLE
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse when the last result is accepted
ap_ready  out  1  identical to ap_done
base  in  32  first flat index; latched at start
count  in  32  number of indices to emit; latched at start
mul_din0  out  32  multiplier operand 0 = current s0 index
mul_din1  out  36  multiplier operand 1 = MAGIC (constant)
mul_dout  in  68  multiplier product, combinational from mul_din0/mul_din1
out_idx  out  32  flat index
out_q  out  32  index / DIVISOR
out_r  out  32  index mod DIVISOR
out_vld  out  1  output valid
out_ack  in  1  downstream accept; a transfer occurs when out_vld && out_ack

Behaviour:
- Reset: state IDLE, ap_idle=1, ap_done=ap_ready=0, out_vld=0, out_idx/out_q/out_r=0, all pipeline valids and counters 0. Reset mid-run discards all in-flight indices; no ap_done is produced.
- FSM states:
  - IDLE -> RUN on ap_start=1; latch base and count; s0 index = base, remaining = count.
  - IDLE -> DONE when ap_start=1 and count=0.
  - RUN: issue one index per unstalled cycle. After the last issue, go to DRAIN.
  - DRAIN: wait until s1 is empty and the final out_vld transfer occurs, then go to DONE.
  - DONE: ap_done=ap_ready=1 for one cycle, then IDLE.
- Pipeline:
  - s0: index register drives mul_din0.
  - s1: registers mul_dout and the index.
  - s2: output registers. out_q = mul_dout_reg[SHIFT+31:SHIFT]; out_r = idx - out_q*DIVISOR, low 32 bits.
- Latency: an index present in s0 at cycle t appears on out_* at t+2 when there is no stall.
- Throughput: one result per cycle while out_ack=1.
- Stall: when out_vld=1 and out_ack=0, s0, s1 and s2 all hold, and the counters hold.
- Simultaneous events:
  - If s2 is accepted in the same cycle s1 is valid, s2 reloads from s1 in that cycle (no bubble).
  - If out_vld=0, s2 loads regardless of out_ack.
- Index wrap: base+k is computed modulo 2^32. An index of 0xFFFFFFFF followed by 0 is legal.
- ap_start outside IDLE is ignored.
- Division result must be exact for every 32-bit index with the default parameters. Any change to DIVISOR requires recomputing MAGIC and SHIFT.
- out_* hold their last values when out_vld=0.

Test Plan:
- Reset, then base=0, count=4, out_ack=1 -> results (0,0,0), (1,0,1), (2,0,2), (3,0,3) on four consecutive cycles; first out_vld 2 cycles after s0 issue; ap_done pulses once, then ap_idle=1.
- base=26, count=3 -> (26,0,26), (27,0,27), (28,1,0), crossing the tile boundary.
- base=0xFFFFFFF0, count=17 -> first result q=153391688, r=16; index 0xFFFFFFFF gives q=153391689, r=3; the last result wraps to idx 0 with q=0, r=0.
- base=100, count=6, out_ack toggling 1,0,0,1,0,1... -> exactly 6 transfers in order 100..105 (q=3, r=16..21); no duplicates or drops; outputs stable while stalled.
- count=0 with ap_start -> out_vld never asserted; ap_done one-cycle pulse within 2 cycles; ap_start held during RUN is ignored.
- ap_rst asserted mid-run with 3 items in flight -> next cycle out_vld=0, ap_idle=1, no ap_done; a new start with base=5, count=1 yields (5,0,5).
